// File: rtl/snake_body_engine_if.sv
// Signal bundle between the snake game-state core and its surroundings
// (inputs, game tick, food position, VGA counters, state and pixel outputs).
interface snake_body_if;
   logic       i_Game_Tick;
   logic       i_Up;
   logic       i_Down;
   logic       i_Left;
   logic       i_Right;
   logic [5:0] i_Food_X;
   logic [4:0] i_Food_Y;
   logic [9:0] i_Col_Count;
   logic [9:0] i_Row_Count;
   logic [5:0] o_Head_X;
   logic [4:0] o_Head_Y;
   logic [4:0] o_Length;
   logic       o_Ate;
   logic       o_Game_Over;
   logic       o_Head_Pixel;
   logic       o_Body_Pixel;

   modport master (
      output i_Game_Tick, i_Up, i_Down, i_Left, i_Right,
      output i_Food_X, i_Food_Y, i_Col_Count, i_Row_Count,
      input  o_Head_X, o_Head_Y, o_Length, o_Ate, o_Game_Over,
      input  o_Head_Pixel, o_Body_Pixel
   );

   modport slave (
      input  i_Game_Tick, i_Up, i_Down, i_Left, i_Right,
      input  i_Food_X, i_Food_Y, i_Col_Count, i_Row_Count,
      output o_Head_X, o_Head_Y, o_Length, o_Ate, o_Game_Over,
      output o_Head_Pixel, o_Body_Pixel
   );
endinterface

// File: rtl/snake_body_engine.sv
// Snake game-state core: segment array, direction, tick-driven movement, growth,
// wall/self collision and per-pixel snake lookup. Define SNAKE_WRAP_EN to wrap at the grid edges.
module snake_body_engine #(
   parameter int GRID_COLS  = 40,
   parameter int GRID_ROWS  = 30,
   parameter int CELL_SHIFT = 4,
   parameter int MAX_LEN    = 16,
   parameter int INIT_LEN   = 3,
   parameter int START_X    = 20,
   parameter int START_Y    = 15
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   snake_body_if.slave bus
);

   localparam int X_W = 6;
   localparam int Y_W = 5;
   localparam int L_W = 5;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DEAD} state_t;
   typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_t;

   state_t         state_reg;
   dir_t           dir_reg;
   dir_t           pending_reg;
   logic [L_W-1:0] len_reg;
   logic           ate_reg;
   logic           game_over_reg;
   logic           tick_d_reg;
   logic           tick_edge_reg;
   logic [3:0]     btn_d_reg;
   logic [3:0]     btn_edge_reg;
   logic           head_pix_reg;
   logic           body_pix_reg;

   logic [X_W-1:0] seg_x_reg [MAX_LEN];
   logic [Y_W-1:0] seg_y_reg [MAX_LEN];

   logic [3:0]     btn_now;
   logic           btn_any;
   dir_t           btn_dir;
   dir_t           btn_dir_opp;
   logic [X_W-1:0] next_x;
   logic [Y_W-1:0] next_y;
   logic           wall_hit;
   logic           eat_hit;
   logic [L_W-1:0] hit_limit;
   logic [MAX_LEN-1:0] seg_hit;
   logic [MAX_LEN-1:0] body_match;
   logic           kill;
   logic           move_en;
   logic           reinit;
   logic [X_W-1:0] cell_x;
   logic [5:0]     cell_y;
   logic           cell_in_grid;

   assign btn_now = {bus.i_Up, bus.i_Down, bus.i_Left, bus.i_Right};
   assign btn_any = |btn_edge_reg;

   always_comb begin
      if (btn_edge_reg[3])      btn_dir = DIR_UP;
      else if (btn_edge_reg[2]) btn_dir = DIR_DOWN;
      else if (btn_edge_reg[1]) btn_dir = DIR_LEFT;
      else                      btn_dir = DIR_RIGHT;
   end

   // Opposite directions differ only in bit 0 of the encoding.
   assign btn_dir_opp = dir_t'(btn_dir ^ 2'b01);

   // Next head uses the pending direction, which commits on this same tick.
   // Coordinates always wrap; without wrap mode the wall flag kills before they are used.
   always_comb begin
      next_x = seg_x_reg[0];
      next_y = seg_y_reg[0];
      case (pending_reg)
         DIR_UP:   next_y = (seg_y_reg[0] == '0) ? Y_W'(GRID_ROWS - 1) : seg_y_reg[0] - 1'b1;
         DIR_DOWN: next_y = (seg_y_reg[0] == Y_W'(GRID_ROWS - 1)) ? '0 : seg_y_reg[0] + 1'b1;
         DIR_LEFT: next_x = (seg_x_reg[0] == '0) ? X_W'(GRID_COLS - 1) : seg_x_reg[0] - 1'b1;
         default:  next_x = (seg_x_reg[0] == X_W'(GRID_COLS - 1)) ? '0 : seg_x_reg[0] + 1'b1;
      endcase
   end

`ifdef SNAKE_WRAP_EN
   assign wall_hit = 1'b0;
`else
   assign wall_hit = ((pending_reg == DIR_UP)    && (seg_y_reg[0] == '0)) ||
                     ((pending_reg == DIR_DOWN)  && (seg_y_reg[0] == Y_W'(GRID_ROWS - 1))) ||
                     ((pending_reg == DIR_LEFT)  && (seg_x_reg[0] == '0)) ||
                     ((pending_reg == DIR_RIGHT) && (seg_x_reg[0] == X_W'(GRID_COLS - 1)));
`endif

   assign eat_hit   = (next_x == bus.i_Food_X) && (next_y == bus.i_Food_Y);
   // The tail vacates its cell on a plain move but stays put when the snake grows.
   assign hit_limit = eat_hit ? len_reg : len_reg - 1'b1;

   assign cell_x       = X_W'(bus.i_Col_Count >> CELL_SHIFT);
   assign cell_y       = 6'(bus.i_Row_Count >> CELL_SHIFT);
   assign cell_in_grid = (cell_x < X_W'(GRID_COLS)) && (cell_y < 6'(GRID_ROWS));

   generate
      for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_seg_cmp
         assign seg_hit[gi] = (L_W'(gi) < hit_limit) &&
                              (seg_x_reg[gi] == next_x) && (seg_y_reg[gi] == next_y);
         if (gi == 0) begin : g_head
            assign body_match[gi] = 1'b0;
         end else begin : g_body
            assign body_match[gi] = (L_W'(gi) < len_reg) &&
                                    (seg_x_reg[gi] == cell_x) && (seg_y_reg[gi] == cell_y[Y_W-1:0]);
         end
      end
   endgenerate

   assign kill    = wall_hit || (|seg_hit);
   assign move_en = (state_reg == ST_RUN) && tick_edge_reg && !kill;
   assign reinit  = (state_reg == ST_DEAD) && btn_any;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_reg     <= ST_IDLE;
         dir_reg       <= DIR_RIGHT;
         pending_reg   <= DIR_RIGHT;
         len_reg       <= L_W'(INIT_LEN);
         ate_reg       <= 1'b0;
         game_over_reg <= 1'b0;
         tick_d_reg    <= 1'b0;
         tick_edge_reg <= 1'b0;
         btn_d_reg     <= '0;
         btn_edge_reg  <= '0;
      end else begin
         tick_d_reg    <= bus.i_Game_Tick;
         tick_edge_reg <= bus.i_Game_Tick & ~tick_d_reg;
         btn_d_reg     <= btn_now;
         btn_edge_reg  <= btn_now & ~btn_d_reg;
         ate_reg       <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (btn_any) begin
                  state_reg <= ST_RUN;
                  if (btn_dir_opp != dir_reg) pending_reg <= btn_dir;
               end
            end
            ST_RUN: begin
               if (tick_edge_reg) begin
                  if (kill) begin
                     state_reg     <= ST_DEAD;
                     game_over_reg <= 1'b1;
                  end else begin
                     dir_reg <= pending_reg;
                     ate_reg <= eat_hit;
                     if (eat_hit && (len_reg < L_W'(MAX_LEN))) len_reg <= len_reg + 1'b1;
                  end
               end
               if (btn_any && (btn_dir_opp != dir_reg)) pending_reg <= btn_dir;
            end
            default: begin
               if (btn_any) begin
                  state_reg     <= ST_IDLE;
                  game_over_reg <= 1'b0;
                  dir_reg       <= DIR_RIGHT;
                  pending_reg   <= DIR_RIGHT;
                  len_reg       <= L_W'(INIT_LEN);
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L || reinit) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_reg[i] <= (i < INIT_LEN) ? X_W'(START_X - i) : '0;
            seg_y_reg[i] <= (i < INIT_LEN) ? Y_W'(START_Y) : '0;
         end
      end else if (move_en) begin
         seg_x_reg[0] <= next_x;
         seg_y_reg[0] <= next_y;
         for (int i = 1; i < MAX_LEN; i++) begin
            seg_x_reg[i] <= seg_x_reg[i-1];
            seg_y_reg[i] <= seg_y_reg[i-1];
         end
      end
   end

   // Registered lookup against the array as it stands before any same-cycle move.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         head_pix_reg <= 1'b0;
         body_pix_reg <= 1'b0;
      end else begin
         head_pix_reg <= cell_in_grid && (seg_x_reg[0] == cell_x) && (seg_y_reg[0] == cell_y[Y_W-1:0]);
         body_pix_reg <= cell_in_grid && (|body_match);
      end
   end

   assign bus.o_Head_X     = seg_x_reg[0];
   assign bus.o_Head_Y     = seg_y_reg[0];
   assign bus.o_Length     = len_reg;
   assign bus.o_Ate        = ate_reg;
   assign bus.o_Game_Over  = game_over_reg;
   assign bus.o_Head_Pixel = head_pix_reg;
   assign bus.o_Body_Pixel = body_pix_reg;

endmodule
